rand_source_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-bit LFSR random source among N requesters (game/effect units). It is the only driver of the LFSR's next strobe. Each granted request advances the LFSR exactly once, captures the fresh value and returns it to the winner with a one-cycle acknowledge. Sits between the LFSR random source instance and its client blocks.

---
 rtl/rand_arb_pkg.sv | 24 ++
 rtl/rand_source_arbiter_rr_pick.sv | 30 +++
 rtl/rand_source_arbiter.sv | 112 +++++++++++
 tb/tb_rand_source_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_arb_pkg.sv
// Shared types and helpers for the random-source arbiter.
package rand_arb_pkg;

    localparam int RAND_W_DEF = 16;

    // Wide enough for LFSR_LAT-1 with LFSR_LAT up to 4.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ADVANCE,
        WAIT,
        DELIVER
    } arb_state_t;

    // Modulo-n increment with an explicit compare, so non-power-of-two n wraps correctly.
    function automatic int next_rr(input int ptr, input int n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/rand_source_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclic.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    // Walk offsets 0..N_REQ-1 from ptr; the first hit wins.
    always_comb begin
        int c;
        c    = 0;
        pick = '0;
        any  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            if (!any && req[c]) begin
                any  = 1'b1;
                pick = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/rand_source_arbiter.sv
// Round-robin arbiter sharing one LFSR random source among N_REQ requesters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; pick a winner round-robin when any request
// ADVANCE | one-cycle o_lfsr_next pulse, load the wait counter
// WAIT    | LFSR_LAT cycles for the LFSR output to settle, then capture
// DELIVER | one-cycle o_ack to the winner, advance the pointer
module rand_source_arbiter
    import rand_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int RAND_W   = RAND_W_DEF,
    parameter int LFSR_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_REQ-1:0]  i_req,
    output logic [N_REQ-1:0]  o_ack,
    output logic [RAND_W-1:0] o_rand,
    output logic              o_busy,
    output logic              o_lfsr_next,
    input  logic [RAND_W-1:0] i_lfsr_rand
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [CNT_W-1:0] wait_cnt;
    logic             dropped;
    logic [IDX_W-1:0] pick;
    logic             any_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (i_req),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any_req)
    );

    // Single-process FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ack       <= '0;
            o_rand      <= '0;
            o_busy      <= 1'b0;
            o_lfsr_next <= 1'b0;
            rr_ptr      <= '0;
            grant       <= '0;
            wait_cnt    <= '0;
            dropped     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_ack <= '0;
                    if (any_req) begin
                        grant       <= pick;
                        dropped     <= 1'b0;
                        o_lfsr_next <= 1'b1;
                        o_busy      <= 1'b1;
                        state       <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    o_lfsr_next <= 1'b0;
                    wait_cnt    <= CNT_W'(LFSR_LAT - 1);
                    if (!i_req[grant]) begin
                        dropped <= 1'b1;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        // A request dropped at any point since the grant forfeits
                        // the word; the LFSR step already taken is not undone.
                        if (dropped || !i_req[grant]) begin
                            rr_ptr <= IDX_W'(next_rr(int'(grant), N_REQ));
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            o_rand       <= i_lfsr_rand;
                            o_ack        <= '0;
                            o_ack[grant] <= 1'b1;
                            state        <= DELIVER;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                        if (!i_req[grant]) begin
                            dropped <= 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    o_ack  <= '0;
                    rr_ptr <= IDX_W'(next_rr(int'(grant), N_REQ));
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_source_arbiter.sv
// Directed bench for rand_source_arbiter: one LFSR_LAT=1 instance, one LFSR_LAT=3 instance.
module tb_rand_source_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req1, ack1, req3, ack3;
    logic [15:0] rand1, rand3;
    logic        busy1, next1, busy3, next3;

    logic [15:0] lfsr1 = 16'h0000;
    logic [15:0] p3_q  = 16'h0000;
    logic [15:0] p3_d1 = 16'h0000;
    logic [15:0] p3_d2 = 16'h0000;
    int          mode1;
    logic [15:0] const1;
    logic        load1;
    logic [15:0] seed1;

    int pulses1 = 0;
    int pulses3 = 0;
    int cyc     = 0;
    int errors  = 0;
    int checks  = 0;

    always #5 clk = ~clk;

    rand_source_arbiter #(.N_REQ(4), .RAND_W(16), .LFSR_LAT(1)) dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req1),
        .o_ack       (ack1),
        .o_rand      (rand1),
        .o_busy      (busy1),
        .o_lfsr_next (next1),
        .i_lfsr_rand (lfsr1)
    );

    rand_source_arbiter #(.N_REQ(4), .RAND_W(16), .LFSR_LAT(3)) dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req3),
        .o_ack       (ack3),
        .o_rand      (rand3),
        .o_busy      (busy3),
        .o_lfsr_next (next3),
        .i_lfsr_rand (p3_d2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    // LFSR stubs: dut1 source has selectable behaviour; dut3 source settles 3 edges after the strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load1) begin
            lfsr1 <= seed1;
        end else if (next1) begin
            case (mode1)
                0:       lfsr1 <= lfsr1 + 16'd1;
                1:       lfsr1 <= const1;
                default: lfsr1 <= lfsr_step(lfsr1);
            endcase
        end
        if (next1) pulses1 <= pulses1 + 1;
        if (next3) begin
            p3_q    <= 16'h1234;
            pulses3 <= pulses3 + 1;
        end
        p3_d1 <= p3_q;
        p3_d2 <= p3_d1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the negedge where ack1 is nonzero, bounded.
    task automatic wait_ack1(input string tag);
        int t;
        t = 0;
        while (ack1 == 4'b0000 && t < 16) begin
            step(1);
            t++;
        end
        check_val(tag, (t < 16) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int bad;
        int p0;
        int last_cyc;
        logic [15:0] exp_rand;
        logic [15:0] last_rand;

        rst_n  = 1'b0;
        req1   = 4'b0000;
        req3   = 4'b0000;
        mode1  = 0;
        const1 = 16'h0000;
        load1  = 1'b0;
        seed1  = 16'h0000;

        // 1: reset state, then quiet idle with no requests
        step(3);
        check_val("rst_ack",  {28'd0, ack1}, 32'd0);
        check_val("rst_rand", {16'd0, rand1}, 32'd0);
        check_val("rst_busy", {31'd0, busy1}, 32'd0);
        check_val("rst_next", {31'd0, next1}, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (next1 || busy1 || ack1 != 4'b0000 || rand1 != 16'h0000) bad++;
        end
        check_val("idle_quiet",  bad, 0);
        check_val("idle_pulses", pulses1, 0);

        // 2: single request, LFSR_LAT=1 timing
        mode1  = 1;
        const1 = 16'hACE1;
        req1   = 4'b0010;
        step(1);
        check_val("t2_c1_next", {31'd0, next1}, 32'd1);
        check_val("t2_c1_busy", {31'd0, busy1}, 32'd1);
        check_val("t2_c1_ack",  {28'd0, ack1}, 32'd0);
        step(1);
        check_val("t2_c2_next", {31'd0, next1}, 32'd0);
        check_val("t2_c2_ack",  {28'd0, ack1}, 32'd0);
        check_val("t2_c2_busy", {31'd0, busy1}, 32'd1);
        step(1);
        check_val("t2_c3_ack",  {28'd0, ack1}, 32'h2);
        check_val("t2_c3_rand", {16'd0, rand1}, 32'hACE1);
        check_val("t2_c3_busy", {31'd0, busy1}, 32'd1);
        req1 = 4'b0000;
        step(1);
        check_val("t2_c4_ack",  {28'd0, ack1}, 32'd0);
        check_val("t2_c4_busy", {31'd0, busy1}, 32'd0);
        check_val("t2_pulses",  pulses1, 1);

        // 3: all requesting with a real LFSR; fair order and one step per ack
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        load1 = 1'b1;
        seed1 = 16'hACE1;
        step(1);
        load1    = 1'b0;
        mode1    = 2;
        exp_rand = 16'hACE1;
        p0       = pulses1;
        last_cyc = 0;
        req1     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack1("t3_timeout");
            exp_rand = lfsr_step(exp_rand);
            check_val("t3_ack",    {28'd0, ack1}, 32'd1 << (k % 4));
            check_val("t3_rand",   {16'd0, rand1}, {16'd0, exp_rand});
            check_val("t3_pulses", pulses1 - p0, k + 1);
            if (k > 0) check_val("t3_gap", cyc - last_cyc, 4);
            last_cyc = cyc;
            step(1);
        end
        req1      = 4'b0000;
        last_rand = rand1;

        // 4: winner drops during WAIT
        step(2);
        p0   = pulses1;
        req1 = 4'b0100;
        step(2);
        req1 = 4'b0000;
        bad  = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (ack1 != 4'b0000) bad++;
        end
        check_val("t4_no_ack",    bad, 0);
        check_val("t4_pulses",    pulses1 - p0, 1);
        check_val("t4_rand_hold", {16'd0, rand1}, {16'd0, last_rand});
        check_val("t4_busy",      {31'd0, busy1}, 32'd0);
        req1 = 4'b1100;
        wait_ack1("t4_timeout");
        check_val("t4_next_win", {28'd0, ack1}, 32'h8);
        req1 = 4'b0000;
        step(2);

        // 5: LFSR_LAT=3 latency and capture point
        req3 = 4'b0001;
        step(1);
        check_val("t5_next", {31'd0, next3}, 32'd1);
        req3 = 4'b0001;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (ack3 != 4'b0000) bad++;
        end
        check_val("t5_early_ack", bad, 0);
        check_val("t5_pre_rand",  {16'd0, rand3}, 32'd0);
        step(1);
        check_val("t5_ack",    {28'd0, ack3}, 32'h1);
        check_val("t5_rand",   {16'd0, rand3}, 32'h1234);
        check_val("t5_pulses", pulses3, 1);
        req3 = 4'b0000;
        step(2);

        // 6: async reset in mid-WAIT, then normal service from index 0
        mode1  = 1;
        const1 = 16'hBEEF;
        req1   = 4'b0001;
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_ack",  {28'd0, ack1}, 32'd0);
        check_val("t6_busy", {31'd0, busy1}, 32'd0);
        check_val("t6_next", {31'd0, next1}, 32'd0);
        check_val("t6_rand", {16'd0, rand1}, 32'd0);
        req1 = 4'b0000;
        step(1);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (ack1 != 4'b0000) bad++;
        end
        check_val("t6_no_ack", bad, 0);
        const1 = 16'h5A5A;
        req1   = 4'b1001;
        wait_ack1("t6_timeout");
        check_val("t6_re_ack",  {28'd0, ack1}, 32'h1);
        check_val("t6_re_rand", {16'd0, rand1}, 32'h5A5A);
        req1 = 4'b0000;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
